// File: rtl/fifo_w2n_sync.sv
// Single-clock wide-to-narrow width-converting FIFO with backpressure, flush and prog_full.
// Define FIFO_W2N_OVF_EN to build the sticky overflow flag; otherwise ovf is tied low.
module fifo_w2n_sync #(
    parameter int DWO        = 4,
    parameter int RATIO      = 4,
    parameter int DEPTH      = 8,
    parameter int PROG_DEPTH = 6,
    parameter int MSB_FIRST  = 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      flush,
    input  logic [DWO*RATIO-1:0]      din,
    input  logic                      din_en,
    output logic                      full,
    output logic                      prog_full,
    output logic [$clog2(DEPTH):0]    level,
    output logic [DWO-1:0]            dout,
    output logic                      dout_en,
    input  logic                      dout_rdy,
    output logic                      ovf
);

    localparam int DWI = DWO * RATIO;
    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int SW  = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [DWI-1:0] r_mem [DEPTH];
    logic [AW-1:0]  r_wp;
    logic [AW-1:0]  r_rp;
    logic [SW-1:0]  r_sidx;
    logic [LW-1:0]  r_level;

    logic           w_full;
    logic           w_empty;
    logic           w_lastSlice;
    logic           w_wr;
    logic           w_acc;
    logic           w_pop;
    logic [DWI-1:0] w_head;
    logic [SW-1:0]  w_sliceIdx;
    logic [DWO-1:0] w_slices [RATIO];

    assign w_full      = (r_level == LW'(DEPTH));
    assign w_empty     = (r_level == '0);
    assign w_lastSlice = (r_sidx == SW'(RATIO - 1));
    // Flags come from the registered level so a pop cannot free room for a same-cycle write.
    assign w_wr        = din_en && !w_full && !flush;
    assign w_acc       = dout_rdy && !w_empty && !flush;
    assign w_pop       = w_acc && w_lastSlice;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr) begin
            r_mem[r_wp] <= din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_sidx  <= '0;
            r_level <= '0;
        end else if (flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_sidx  <= '0;
            r_level <= '0;
        end else begin
            if (w_wr) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_acc) begin
                if (w_lastSlice) begin
                    r_sidx <= '0;
                    r_rp   <= r_rp + AW'(1);
                end else begin
                    r_sidx <= r_sidx + SW'(1);
                end
            end
            if (w_wr && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (!w_wr && w_pop) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

    assign w_head = r_mem[r_rp];

    always_comb begin
        for (int i = 0; i < RATIO; i++) begin
            w_slices[i] = w_head[i*DWO +: DWO];
        end
    end

    generate
        if (MSB_FIRST != 0) begin : g_msbFirst
            assign w_sliceIdx = SW'(RATIO - 1) - r_sidx;
        end else begin : g_lsbFirst
            assign w_sliceIdx = r_sidx;
        end
    endgenerate

    assign dout      = w_slices[w_sliceIdx];
    assign dout_en   = !w_empty;
    assign full      = w_full;
    assign prog_full = (r_level >= LW'(PROG_DEPTH));
    assign level     = r_level;

`ifdef FIFO_W2N_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ovf <= 1'b0;
        end else if (flush) begin
            r_ovf <= 1'b0;
        end else if (din_en && w_full) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_w2n_sync.sv
// Self-checking bench for fifo_w2n_sync: directed scenarios plus random traffic against a queue model.
// Two instances share all inputs, one emitting MSB slice first and one LSB first.
module tb_fifo_w2n_sync;

    localparam int DWO   = 4;
    localparam int RATIO = 4;
    localparam int DEPTH = 8;
    localparam int PROG  = 6;
`ifdef FIFO_W2N_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        flush = 1'b0;
    logic [15:0] din = '0;
    logic        din_en = 1'b0;
    logic        dout_rdy = 1'b0;
    logic        full, prog_full, dout_en, ovf;
    logic [3:0]  level;
    logic [3:0]  dout;
    logic        fullL, progFullL, doutEnL, ovfL;
    logic [3:0]  levelL;
    logic [3:0]  doutL;

    int compared = 0;
    int mismatched = 0;

    // Reference model: queue of whole words plus the number of slices already taken from the head.
    logic [15:0] q[$];
    int          mSidx = 0;
    bit          mOvf = 1'b0;

    always #5 clk = ~clk;

    fifo_w2n_sync #(.DWO(DWO), .RATIO(RATIO), .DEPTH(DEPTH), .PROG_DEPTH(PROG), .MSB_FIRST(1)) u_dut (
        .clk(clk), .rstn(rstn), .flush(flush), .din(din), .din_en(din_en),
        .full(full), .prog_full(prog_full), .level(level), .dout(dout),
        .dout_en(dout_en), .dout_rdy(dout_rdy), .ovf(ovf)
    );

    fifo_w2n_sync #(.DWO(DWO), .RATIO(RATIO), .DEPTH(DEPTH), .PROG_DEPTH(PROG), .MSB_FIRST(0)) u_dutLsb (
        .clk(clk), .rstn(rstn), .flush(flush), .din(din), .din_en(din_en),
        .full(fullL), .prog_full(progFullL), .level(levelL), .dout(doutL),
        .dout_en(doutEnL), .dout_rdy(dout_rdy), .ovf(ovfL)
    );

    function automatic logic [3:0] sliceOf(input logic [15:0] w, input int k, input bit msb);
        int pos;
        pos = msb ? (RATIO - 1 - k) : k;
        return 4'(w >> (DWO * pos));
    endfunction

    function automatic logic [3:0] modelSlice(input bit msb);
        if (q.size() == 0) return 4'h0;
        return sliceOf(q[0], mSidx, msb);
    endfunction

    // Drive one clock cycle of inputs, advance the model at the edge, return at the falling edge.
    task automatic cycle(input bit en, input logic [15:0] d, input bit rdy, input bit fl);
        bit wasFull;
        din_en = en; din = d; dout_rdy = rdy; flush = fl;
        @(posedge clk);
        if (fl) begin
            q.delete(); mSidx = 0; mOvf = 1'b0;
        end else begin
            wasFull = (q.size() == DEPTH);
            if (rdy && q.size() > 0) begin
                if (mSidx == RATIO - 1) begin
                    void'(q.pop_front()); mSidx = 0;
                end else begin
                    mSidx++;
                end
            end
            if (en && !wasFull) q.push_back(d);
            if (en && wasFull && OVF_EN) mOvf = 1'b1;
        end
        @(negedge clk);
        din_en = 1'b0; dout_rdy = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        #2 rstn = 1'b0;
        #3;
        compared++;
        if ({level, full, prog_full, dout_en, ovf, dout, doutL} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs got lvl=%0d f=%b pf=%b en=%b ovf=%b dout=%h doutL=%h want all 0",
                     level, full, prog_full, dout_en, ovf, dout, doutL);
        end
        q.delete(); mSidx = 0; mOvf = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_abcd();
        logic [3:0] msbSeq [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
        logic [3:0] lsbSeq [4] = '{4'hD, 4'hC, 4'hB, 4'hA};
        cycle(1'b1, 16'hABCD, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (dout_en !== 1'b1 || dout !== msbSeq[i] || doutL !== lsbSeq[i] || level !== 4'd1) begin
                mismatched++;
                $display("[TB] FAIL abcd_slice%0d got en=%b dout=%h doutL=%h lvl=%0d want en=1 dout=%h doutL=%h lvl=1",
                         i, dout_en, dout, doutL, level, msbSeq[i], lsbSeq[i]);
            end
            cycle(1'b0, 16'h0, 1'b1, 1'b0);
        end
        compared++;
        if (level !== 4'd0 || dout_en !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL abcd_empty got lvl=%0d en=%b want lvl=0 en=0", level, dout_en);
        end
    endtask

    task automatic test_full();
        logic [15:0] words [8];
        for (int i = 0; i < 8; i++) begin
            words[i] = 16'($urandom);
            cycle(1'b1, words[i], 1'b0, 1'b0);
            compared++;
            if (level !== 4'(i + 1) || full !== (i == 7) || prog_full !== (i + 1 >= PROG)) begin
                mismatched++;
                $display("[TB] FAIL fill_write%0d got lvl=%0d f=%b pf=%b want lvl=%0d f=%b pf=%b",
                         i + 1, level, full, prog_full, i + 1, (i == 7), (i + 1 >= PROG));
            end
        end
        cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
        compared++;
        if (level !== 4'd8 || full !== 1'b1 || ovf !== OVF_EN) begin
            mismatched++;
            $display("[TB] FAIL overflow_write got lvl=%0d f=%b ovf=%b want lvl=8 f=1 ovf=%b", level, full, ovf, OVF_EN);
        end
        for (int s = 0; s < 32; s++) begin
            compared++;
            if (dout_en !== 1'b1 || dout !== sliceOf(words[s/4], s%4, 1'b1) || doutL !== sliceOf(words[s/4], s%4, 1'b0)) begin
                mismatched++;
                $display("[TB] FAIL drain_slice%0d got en=%b dout=%h doutL=%h want en=1 dout=%h doutL=%h",
                         s, dout_en, dout, doutL, sliceOf(words[s/4], s%4, 1'b1), sliceOf(words[s/4], s%4, 1'b0));
            end
            cycle(1'b0, 16'h0, 1'b1, 1'b0);
        end
        compared++;
        if (level !== 4'd0 || dout_en !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL drain_empty got lvl=%0d en=%b want lvl=0 en=0", level, dout_en);
        end
    endtask

    task automatic test_toggle();
        logic [15:0] words [3];
        logic [3:0]  prev;
        bit          rdy;
        int          n = 0;
        for (int i = 0; i < 3; i++) begin
            words[i] = 16'($urandom);
            cycle(1'b1, words[i], 1'b0, 1'b0);
        end
        for (int t = 0; t < 40 && n < 12; t++) begin
            rdy = (t % 2 == 0);
            prev = dout;
            if (rdy) begin
                compared++;
                if (dout_en !== 1'b1 || dout !== sliceOf(words[n/4], n%4, 1'b1)) begin
                    mismatched++;
                    $display("[TB] FAIL toggle_slice%0d got en=%b dout=%h want en=1 dout=%h",
                             n, dout_en, dout, sliceOf(words[n/4], n%4, 1'b1));
                end
                n++;
            end
            cycle(1'b0, 16'h0, rdy, 1'b0);
            if (!rdy) begin
                compared++;
                if (dout !== prev) begin
                    mismatched++;
                    $display("[TB] FAIL toggle_hold got dout=%h want %h", dout, prev);
                end
            end
        end
        compared++;
        if (n !== 12 || level !== 4'd0) begin
            mismatched++;
            $display("[TB] FAIL toggle_count got slices=%0d lvl=%0d want slices=12 lvl=0", n, level);
        end
    endtask

    task automatic test_flush(input bit useReset);
        logic [15:0] w;
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        compared++;
        if (level !== 4'd4) begin
            mismatched++;
            $display("[TB] FAIL clear_setup got lvl=%0d want 4", level);
        end
        if (useReset) begin
            rstn = 1'b0;
            #1;
            compared++;
            if (level !== 4'd0 || dout_en !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL async_reset got lvl=%0d en=%b want lvl=0 en=0", level, dout_en);
            end
            q.delete(); mSidx = 0; mOvf = 1'b0;
            @(negedge clk);
            rstn = 1'b1;
        end else begin
            cycle(1'b1, 16'($urandom), 1'b1, 1'b1);
        end
        compared++;
        if (level !== 4'd0 || dout_en !== 1'b0 || ovf !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL clear_state rst=%b got lvl=%0d en=%b ovf=%b want 0 0 0", useReset, level, dout_en, ovf);
        end
        w = 16'($urandom);
        cycle(1'b1, w, 1'b0, 1'b0);
        compared++;
        if (dout_en !== 1'b1 || dout !== w[15:12] || doutL !== w[3:0]) begin
            mismatched++;
            $display("[TB] FAIL clear_restart rst=%b got en=%b dout=%h doutL=%h want en=1 dout=%h doutL=%h",
                     useReset, dout_en, dout, doutL, w[15:12], w[3:0]);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [4];
        cycle(1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            words[i] = 16'($urandom);
            cycle(1'b1, words[i], 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0);
        words[3] = 16'($urandom);
        cycle(1'b1, words[3], 1'b1, 1'b0);
        compared++;
        if (level !== 4'd3) begin
            mismatched++;
            $display("[TB] FAIL wrap_level got lvl=%0d want 3", level);
        end
        for (int s = 0; s < 12; s++) begin
            compared++;
            if (dout_en !== 1'b1 || dout !== sliceOf(words[1 + s/4], s%4, 1'b1)) begin
                mismatched++;
                $display("[TB] FAIL wrap_slice%0d got en=%b dout=%h want en=1 dout=%h",
                         s, dout_en, dout, sliceOf(words[1 + s/4], s%4, 1'b1));
            end
            cycle(1'b0, 16'h0, 1'b1, 1'b0);
        end
        compared++;
        if (level !== 4'd0) begin
            mismatched++;
            $display("[TB] FAIL wrap_empty got lvl=%0d want 0", level);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            cycle($urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
            compared++;
            if (level !== 4'(q.size())) begin
                mismatched++;
                $display("[TB] FAIL rand_level t=%0d got %0d want %0d", t, level, q.size());
            end
            compared++;
            if ({full, prog_full, dout_en, ovf} !== {q.size() == DEPTH, q.size() >= PROG, q.size() > 0, mOvf}) begin
                mismatched++;
                $display("[TB] FAIL rand_flags t=%0d got f=%b pf=%b en=%b ovf=%b want f=%b pf=%b en=%b ovf=%b", t,
                         full, prog_full, dout_en, ovf, q.size() == DEPTH, q.size() >= PROG, q.size() > 0, mOvf);
            end
            if (q.size() > 0) begin
                compared++;
                if (dout !== modelSlice(1'b1) || doutL !== modelSlice(1'b0)) begin
                    mismatched++;
                    $display("[TB] FAIL rand_dout t=%0d got dout=%h doutL=%h want dout=%h doutL=%h",
                             t, dout, doutL, modelSlice(1'b1), modelSlice(1'b0));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_abcd();
        test_full();
        test_toggle();
        test_flush(1'b0);
        test_flush(1'b1);
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
